// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station.
package reservation_station_pkg;

    typedef enum logic [4:0] {
        OPENUM_NOP,
        OPENUM_ADD,
        OPENUM_SUB,
        OPENUM_AND,
        OPENUM_OR,
        OPENUM_XOR,
        OPENUM_SLL,
        OPENUM_SRL,
        OPENUM_SRA,
        OPENUM_SLT,
        OPENUM_SLTU,
        OPENUM_ADDI,
        OPENUM_LUI,
        OPENUM_AUIPC,
        OPENUM_BEQ,
        OPENUM_BNE,
        OPENUM_BLT,
        OPENUM_BGE,
        OPENUM_JAL,
        OPENUM_JALR
    } OPENUM_TYPE;

    localparam int unsigned ROB_ID_W = 5;
    typedef logic [ROB_ID_W-1:0] ROB_ID_TYPE;
    // Tag value meaning "operand already available".
    localparam ROB_ID_TYPE ZERO_ROB = '0;

    typedef logic [31:0] DATA_TYPE;
    typedef logic [31:0] ADDR_TYPE;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Default geometry; the top exposes RS_SIZE / RS_IDX_W as its own parameters.
    localparam int unsigned DEF_RS_SIZE  = 16;
    localparam int unsigned DEF_RS_IDX_W = 4;
    typedef logic [DEF_RS_IDX_W-1:0] RS_IDX_TYPE;

    typedef struct packed {
        ROB_ID_TYPE q;
        DATA_TYPE   v;
    } operand_t;

    typedef struct packed {
        logic       busy;
        OPENUM_TYPE openum;
        operand_t   op1;
        operand_t   op2;
        ADDR_TYPE   pc;
        DATA_TYPE   imm;
        ROB_ID_TYPE rob_id;
    } rs_entry_t;

    // Resolve one operand against both CDBs; the arith CDB wins a tag collision.
    function automatic operand_t snoop(input operand_t   op,
                                       input logic       a_vld,
                                       input ROB_ID_TYPE a_tag,
                                       input DATA_TYPE   a_res,
                                       input logic       l_vld,
                                       input ROB_ID_TYPE l_tag,
                                       input DATA_TYPE   l_res);
        operand_t r;
        r = op;
        if (a_vld && (op.q != ZERO_ROB) && (op.q == a_tag)) begin
            r.q = ZERO_ROB;
            r.v = a_res;
        end else if (l_vld && (op.q != ZERO_ROB) && (op.q == l_tag)) begin
            r.q = ZERO_ROB;
            r.v = l_res;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_priority_finder.sv
// Lowest-set-bit encoder: index of the lowest requesting bit plus a found flag.
module rs_priority_finder #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers ALU-bound instructions until both operands are
// available, wakes operands from the arith and LS CDBs, issues one per cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE  = DEF_RS_SIZE,
    parameter int unsigned RS_IDX_W = DEF_RS_IDX_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,

    input  logic       ena_from_dsp,
    input  OPENUM_TYPE openum_from_dsp,
    input  DATA_TYPE   V1_from_dsp,
    input  DATA_TYPE   V2_from_dsp,
    input  ROB_ID_TYPE Q1_from_dsp,
    input  ROB_ID_TYPE Q2_from_dsp,
    input  ADDR_TYPE   pc_from_dsp,
    input  DATA_TYPE   imm_from_dsp,
    input  ROB_ID_TYPE rob_id_from_dsp,

    input  logic       valid_from_Arith_unit_cdb,
    input  ROB_ID_TYPE rob_id_from_Arith_unit_cdb,
    input  DATA_TYPE   result_from_Arith_unit_cdb,
    input  logic       valid_from_LS_unit_cdb,
    input  ROB_ID_TYPE rob_id_from_LS_unit_cdb,
    input  DATA_TYPE   result_from_LS_unit_cdb,

    input  logic       misbranch_flag,

    output logic       full_to_if,
    output logic       ena_to_alu,
    output OPENUM_TYPE openum_to_alu,
    output DATA_TYPE   V1_to_alu,
    output DATA_TYPE   V2_to_alu,
    output ADDR_TYPE   pc_to_alu,
    output DATA_TYPE   imm_to_alu,
    output ROB_ID_TYPE rob_id_to_alu
);

    rs_entry_t           entry_q [RS_SIZE];
    rs_entry_t           entry_d [RS_SIZE];
    rs_entry_t           alloc_entry;
    logic [RS_SIZE-1:0]  busy_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic [RS_IDX_W-1:0] free_idx;
    logic [RS_IDX_W-1:0] issue_idx;
    logic                free_found;
    logic                issue_found;
    logic [RS_IDX_W:0]   busy_cnt;

    // Busy / ready vectors from registered state only.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entry_q[i].busy;
            ready_vec[i] = entry_q[i].busy && (entry_q[i].op1.q == ZERO_ROB)
                           && (entry_q[i].op2.q == ZERO_ROB);
        end
    end

    rs_priority_finder #(
        .N (RS_SIZE),
        .W (RS_IDX_W)
    ) u_free_finder (
        .req   (~busy_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_finder #(
        .N (RS_SIZE),
        .W (RS_IDX_W)
    ) u_issue_finder (
        .req   (ready_vec),
        .idx   (issue_idx),
        .found (issue_found)
    );

    // Occupancy count; the two-slot margin covers the dispatcher and fetch stages.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_cnt = busy_cnt + (RS_IDX_W + 1)'(busy_vec[i]);
        end
        full_to_if = (busy_cnt >= (RS_IDX_W + 1)'(RS_SIZE - 2));
    end

    // Incoming instruction, with its operands snooped against this cycle's CDBs.
    always_comb begin
        alloc_entry        = '0;
        alloc_entry.busy   = TRUE;
        alloc_entry.openum = openum_from_dsp;
        alloc_entry.op1    = snoop('{q: Q1_from_dsp, v: V1_from_dsp},
                                   valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb,
                                   result_from_Arith_unit_cdb,
                                   valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb,
                                   result_from_LS_unit_cdb);
        alloc_entry.op2    = snoop('{q: Q2_from_dsp, v: V2_from_dsp},
                                   valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb,
                                   result_from_Arith_unit_cdb,
                                   valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb,
                                   result_from_LS_unit_cdb);
        alloc_entry.pc     = pc_from_dsp;
        alloc_entry.imm    = imm_from_dsp;
        alloc_entry.rob_id = rob_id_from_dsp;
    end

    // Next entry state: free the issued slot, wake the others, allocate into a free slot.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].busy) begin
                if (issue_found && (issue_idx == RS_IDX_W'(i))) begin
                    entry_d[i].busy = FALSE;
                end else begin
                    entry_d[i].op1 = snoop(entry_q[i].op1,
                                           valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb,
                                           result_from_Arith_unit_cdb,
                                           valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb,
                                           result_from_LS_unit_cdb);
                    entry_d[i].op2 = snoop(entry_q[i].op2,
                                           valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb,
                                           result_from_Arith_unit_cdb,
                                           valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb,
                                           result_from_LS_unit_cdb);
                end
            end
        end
        // A dispatch into a full station is dropped.
        if (ena_from_dsp && free_found) begin
            entry_d[free_idx] = alloc_entry;
        end
    end

    // State and registered ALU outputs; rst > ~rdy > flush > normal.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            ena_to_alu    <= FALSE;
            openum_to_alu <= OPENUM_NOP;
            V1_to_alu     <= '0;
            V2_to_alu     <= '0;
            pc_to_alu     <= '0;
            imm_to_alu    <= '0;
            rob_id_to_alu <= ZERO_ROB;
        end else if (rdy) begin
            if (misbranch_flag) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    entry_q[i].busy <= FALSE;
                end
                ena_to_alu <= FALSE;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    entry_q[i] <= entry_d[i];
                end
                ena_to_alu <= issue_found;
                if (issue_found) begin
                    openum_to_alu <= entry_q[issue_idx].openum;
                    V1_to_alu     <= entry_q[issue_idx].op1.v;
                    V2_to_alu     <= entry_q[issue_idx].op2.v;
                    pc_to_alu     <= entry_q[issue_idx].pc;
                    imm_to_alu    <= entry_q[issue_idx].imm;
                    rob_id_to_alu <= entry_q[issue_idx].rob_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: table of single-instruction
// dispatches plus hand sequences; issues are matched against a scoreboard queue.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic       clk = 1'b0;
    logic       rst, rdy, ena_from_dsp, misbranch_flag;
    OPENUM_TYPE openum_from_dsp;
    DATA_TYPE   V1_from_dsp, V2_from_dsp, imm_from_dsp;
    ROB_ID_TYPE Q1_from_dsp, Q2_from_dsp, rob_id_from_dsp;
    ADDR_TYPE   pc_from_dsp;
    logic       valid_from_Arith_unit_cdb, valid_from_LS_unit_cdb;
    ROB_ID_TYPE rob_id_from_Arith_unit_cdb, rob_id_from_LS_unit_cdb;
    DATA_TYPE   result_from_Arith_unit_cdb, result_from_LS_unit_cdb;
    logic       full_to_if, ena_to_alu;
    OPENUM_TYPE openum_to_alu;
    DATA_TYPE   V1_to_alu, V2_to_alu, imm_to_alu;
    ADDR_TYPE   pc_to_alu;
    ROB_ID_TYPE rob_id_to_alu;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk                        (clk),
        .rst                        (rst),
        .rdy                        (rdy),
        .ena_from_dsp               (ena_from_dsp),
        .openum_from_dsp            (openum_from_dsp),
        .V1_from_dsp                (V1_from_dsp),
        .V2_from_dsp                (V2_from_dsp),
        .Q1_from_dsp                (Q1_from_dsp),
        .Q2_from_dsp                (Q2_from_dsp),
        .pc_from_dsp                (pc_from_dsp),
        .imm_from_dsp               (imm_from_dsp),
        .rob_id_from_dsp            (rob_id_from_dsp),
        .valid_from_Arith_unit_cdb  (valid_from_Arith_unit_cdb),
        .rob_id_from_Arith_unit_cdb (rob_id_from_Arith_unit_cdb),
        .result_from_Arith_unit_cdb (result_from_Arith_unit_cdb),
        .valid_from_LS_unit_cdb     (valid_from_LS_unit_cdb),
        .rob_id_from_LS_unit_cdb    (rob_id_from_LS_unit_cdb),
        .result_from_LS_unit_cdb    (result_from_LS_unit_cdb),
        .misbranch_flag             (misbranch_flag),
        .full_to_if                 (full_to_if),
        .ena_to_alu                 (ena_to_alu),
        .openum_to_alu              (openum_to_alu),
        .V1_to_alu                  (V1_to_alu),
        .V2_to_alu                  (V2_to_alu),
        .pc_to_alu                  (pc_to_alu),
        .imm_to_alu                 (imm_to_alu),
        .rob_id_to_alu              (rob_id_to_alu)
    );

    typedef struct {
        int         cyc;
        OPENUM_TYPE op;
        DATA_TYPE   v1;
        DATA_TYPE   v2;
        ADDR_TYPE   pc;
        DATA_TYPE   imm;
        ROB_ID_TYPE rob;
    } exp_t;

    typedef struct {
        OPENUM_TYPE op;
        DATA_TYPE   v1;
        DATA_TYPE   v2;
        ROB_ID_TYPE q1;
        ROB_ID_TYPE q2;
        ADDR_TYPE   pc;
        DATA_TYPE   imm;
        ROB_ID_TYPE rob;
        logic       a_vld;
        ROB_ID_TYPE a_tag;
        DATA_TYPE   a_res;
        logic       l_vld;
        ROB_ID_TYPE l_tag;
        DATA_TYPE   l_res;
        DATA_TYPE   e_v1;
        DATA_TYPE   e_v2;
    } vec_t;

    localparam DATA_TYPE JUNK = 32'hBAD0_BAD0;

    exp_t sb[$];
    vec_t tbl[6];
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_issued = 0;
    logic rdy_last = 1'b0;
    logic rst_last = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge counter and the rdy/rst values each edge saw.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rdy_last = rdy;
            rst_last = rst;
        end
    end

    // Issue monitor: every new issue must match the scoreboard head, in order and on time.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_last && rdy_last && ena_to_alu) begin
                n_issued++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_issue: got rob_id %0d pc 0x%0h at cycle %0d, required none",
                             rob_id_to_alu, pc_to_alu, cyc);
                end else begin
                    e = sb.pop_front();
                    check("issue_cycle", cyc, e.cyc);
                    check("issue_openum", openum_to_alu, e.op);
                    check("issue_v1", V1_to_alu, e.v1);
                    check("issue_v2", V2_to_alu, e.v2);
                    check("issue_pc", pc_to_alu, e.pc);
                    check("issue_imm", imm_to_alu, e.imm);
                    check("issue_rob_id", rob_id_to_alu, e.rob);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena_from_dsp              = 1'b0;
        valid_from_Arith_unit_cdb = 1'b0;
        valid_from_LS_unit_cdb    = 1'b0;
        misbranch_flag            = 1'b0;
    endtask

    task automatic dsp(input OPENUM_TYPE op, input DATA_TYPE v1, input DATA_TYPE v2,
                       input ROB_ID_TYPE q1, input ROB_ID_TYPE q2, input ADDR_TYPE pc,
                       input DATA_TYPE imm, input ROB_ID_TYPE rob);
        ena_from_dsp    = 1'b1;
        openum_from_dsp = op;
        V1_from_dsp     = v1;
        V2_from_dsp     = v2;
        Q1_from_dsp     = q1;
        Q2_from_dsp     = q2;
        pc_from_dsp     = pc;
        imm_from_dsp    = imm;
        rob_id_from_dsp = rob;
    endtask

    task automatic arith_cdb(input ROB_ID_TYPE tag, input DATA_TYPE res);
        valid_from_Arith_unit_cdb  = 1'b1;
        rob_id_from_Arith_unit_cdb = tag;
        result_from_Arith_unit_cdb = res;
    endtask

    task automatic ls_cdb(input ROB_ID_TYPE tag, input DATA_TYPE res);
        valid_from_LS_unit_cdb  = 1'b1;
        rob_id_from_LS_unit_cdb = tag;
        result_from_LS_unit_cdb = res;
    endtask

    task automatic expect_issue(input int c, input OPENUM_TYPE op, input DATA_TYPE v1,
                                input DATA_TYPE v2, input ADDR_TYPE pc, input DATA_TYPE imm,
                                input ROB_ID_TYPE rob);
        sb.push_back('{cyc: c, op: op, v1: v1, v2: v2, pc: pc, imm: imm, rob: rob});
    endtask

    // Wait (bounded) for all expected issues, then a couple more cycles for strays.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin : main
        int       base;
        int       iss0;
        DATA_TYPE hold_v1;
        ROB_ID_TYPE hold_rob;

        // op, v1, v2, q1, q2, pc, imm, rob, a_vld, a_tag, a_res, l_vld, l_tag, l_res, e_v1, e_v2
        tbl[0] = '{OPENUM_ADD, 32'd5, 32'd7, 5'd0, 5'd0, 32'h100, 32'h0, 5'd3,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7};
        tbl[1] = '{OPENUM_SUB, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0, 32'h104, 32'h0, 5'd31,
                   1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'd1};
        tbl[2] = '{OPENUM_BEQ, 32'h1234_5678, JUNK, 5'd0, 5'd6, 32'h108, 32'hFFFF_FFF0, 5'd1,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hABCD, 32'h1234_5678, 32'hABCD};
        tbl[3] = '{OPENUM_JAL, JUNK, 32'd0, 5'd7, 5'd0, 32'h10C, 32'h800, 5'd17,
                   1'b1, 5'd7, 32'h111, 1'b1, 5'd7, 32'h222, 32'h111, 32'd0};
        tbl[4] = '{OPENUM_ADDI, JUNK, JUNK, 5'd9, 5'd10, 32'h7FFF_FFFC, 32'hFFF, 5'd8,
                   1'b1, 5'd10, 32'hA0, 1'b1, 5'd9, 32'hB0, 32'hB0, 32'hA0};
        tbl[5] = '{OPENUM_OR, JUNK, JUNK, 5'd12, 5'd12, 32'h110, 32'h4, 5'd2,
                   1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 32'h0, 32'h77, 32'h77};

        rst = 1'b1;
        rdy = 1'b1;
        idle();
        dsp(OPENUM_NOP, 32'h0, 32'h0, ZERO_ROB, ZERO_ROB, 32'h0, 32'h0, ZERO_ROB);
        ena_from_dsp = 1'b0;
        arith_cdb(ZERO_ROB, 32'h0);
        ls_cdb(ZERO_ROB, 32'h0);
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("reset_ena", ena_to_alu, 0);
        check("reset_openum", openum_to_alu, OPENUM_NOP);
        check("reset_v1", V1_to_alu, 0);
        check("reset_v2", V2_to_alu, 0);
        check("reset_pc", pc_to_alu, 0);
        check("reset_imm", imm_to_alu, 0);
        check("reset_rob_id", rob_id_to_alu, 0);
        check("reset_full", full_to_if, 0);

        // Single dispatches, with same-cycle CDB snoop where the vector asks for it.
        for (int i = 0; i < 6; i++) begin
            dsp(tbl[i].op, tbl[i].v1, tbl[i].v2, tbl[i].q1, tbl[i].q2, tbl[i].pc, tbl[i].imm,
                tbl[i].rob);
            if (tbl[i].a_vld) arith_cdb(tbl[i].a_tag, tbl[i].a_res);
            if (tbl[i].l_vld) ls_cdb(tbl[i].l_tag, tbl[i].l_res);
            expect_issue(cyc + 2, tbl[i].op, tbl[i].e_v1, tbl[i].e_v2, tbl[i].pc, tbl[i].imm,
                         tbl[i].rob);
            tick();
            idle();
            tick();
            tick();
            check("single_ena_drops", ena_to_alu, 0);
            check("single_drained", sb.size(), 0);
            sb.delete();
        end

        // Waiting operand woken by the arith CDB two cycles after dispatch.
        dsp(OPENUM_ADD, JUNK, 32'd2, 5'd4, ZERO_ROB, 32'h200, 32'h0, 5'd5);
        tick();
        idle();
        tick();
        arith_cdb(5'd4, 32'h10);
        expect_issue(cyc + 2, OPENUM_ADD, 32'h10, 32'd2, 32'h200, 32'h0, 5'd5);
        tick();
        idle();
        drain("arith_wake_drained", 6);

        // Stored entry with both operands woken from different CDBs on one edge.
        dsp(OPENUM_SLT, JUNK, JUNK, 5'd8, 5'd10, 32'h204, 32'h1, 5'd6);
        tick();
        idle();
        tick();
        arith_cdb(5'd8, 32'hA);
        ls_cdb(5'd10, 32'hB);
        expect_issue(cyc + 2, OPENUM_SLT, 32'hA, 32'hB, 32'h204, 32'h1, 5'd6);
        tick();
        idle();
        drain("dual_wake_drained", 6);

        // Fill 14 entries waiting on tag 9, then drain them in index order.
        for (int i = 0; i < 14; i++) begin
            dsp(OPENUM_ADD, JUNK, DATA_TYPE'(i), 5'd9, ZERO_ROB, ADDR_TYPE'(32'h300 + 4 * i),
                DATA_TYPE'(i), ROB_ID_TYPE'(i + 1));
            tick();
            check("fill_full", full_to_if, (i >= 13));
        end
        idle();
        arith_cdb(5'd9, 32'h99);
        base = cyc;
        for (int i = 0; i < 14; i++) begin
            expect_issue(base + 2 + i, OPENUM_ADD, 32'h99, DATA_TYPE'(i),
                         ADDR_TYPE'(32'h300 + 4 * i), DATA_TYPE'(i), ROB_ID_TYPE'(i + 1));
        end
        tick();
        idle();
        check("full_held_at_14", full_to_if, 1);
        tick();
        check("full_falls_at_13", full_to_if, 0);
        drain("fill_drained", 30);

        // Flush with waiting entries, a ready entry, a dispatch and a CDB hit.
        for (int i = 0; i < 5; i++) begin
            dsp(OPENUM_SUB, JUNK, 32'd1, 5'd11, ZERO_ROB, ADDR_TYPE'(32'h600 + 4 * i), 32'h0,
                ROB_ID_TYPE'(i + 1));
            tick();
        end
        dsp(OPENUM_AND, 32'd1, 32'd2, ZERO_ROB, ZERO_ROB, 32'h614, 32'h0, 5'd6);
        tick();
        iss0 = n_issued;
        dsp(OPENUM_AND, 32'd3, 32'd4, ZERO_ROB, ZERO_ROB, 32'h618, 32'h0, 5'd7);
        arith_cdb(5'd11, 32'h55);
        misbranch_flag = 1'b1;
        tick();
        idle();
        check("flush_ena", ena_to_alu, 0);
        check("flush_full", full_to_if, 0);
        arith_cdb(5'd11, 32'h66);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("flush_no_issue", n_issued - iss0, 0);

        // rdy low for 3 cycles with a ready entry; CDB in the stall is not captured.
        dsp(OPENUM_OR, 32'd1, JUNK, ZERO_ROB, 5'd12, 32'h400, 32'h0, 5'd21);
        tick();
        dsp(OPENUM_XOR, 32'hF0, 32'h0F, ZERO_ROB, ZERO_ROB, 32'h404, 32'h4, 5'd22);
        tick();
        idle();
        rdy = 1'b0;
        arith_cdb(5'd12, 32'h1212);
        hold_v1  = V1_to_alu;
        hold_rob = rob_id_to_alu;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_ena", ena_to_alu, 0);
            check("stall_v1_held", V1_to_alu, hold_v1);
            check("stall_rob_held", rob_id_to_alu, hold_rob);
        end
        rdy = 1'b1;
        idle();
        expect_issue(cyc + 1, OPENUM_XOR, 32'hF0, 32'h0F, 32'h404, 32'h4, 5'd22);
        drain("stall_resume_drained", 6);
        tick();
        tick();
        arith_cdb(5'd12, 32'h3434);
        expect_issue(cyc + 2, OPENUM_OR, 32'd1, 32'h3434, 32'h400, 32'h0, 5'd21);
        tick();
        idle();
        drain("stall_late_wake_drained", 6);

        // Reset mid-operation drops a ready entry before it issues.
        dsp(OPENUM_ADD, 32'd9, 32'd9, ZERO_ROB, ZERO_ROB, 32'h500, 32'h0, 5'd2);
        tick();
        idle();
        iss0 = n_issued;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ena", ena_to_alu, 0);
        check("midrst_v1", V1_to_alu, 0);
        check("midrst_rob_id", rob_id_to_alu, 0);
        tick();
        tick();
        tick();
        check("midrst_no_issue", n_issued - iss0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds arithmetic, branch and jump instructions issued by the dispatcher until both source operands are available, then issues one ready instruction per cycle to the arithmetic unit. It sits directly downstream of the dispatcher's RS port and upstream of the ALU. It snoops both CDBs (arith and LS) to wake up waiting operands. It signals back-pressure to the fetcher.

## Interface
- `RS_SIZE`, 16: number of entries, a power of two ≥ 4.
- `RS_IDX_W`, 4: log2(`RS_SIZE`).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready; when low, all state is frozen.
- `ena_from_dsp` in 1: a valid instruction is present on the dispatcher inputs this cycle.
- `openum_from_dsp` in `OPENUM_TYPE`: operation enum.
- `V1_from_dsp`, `V2_from_dsp` in 32: operand values. Meaningful only when the matching Q is `ZERO_ROB`.
- `Q1_from_dsp`, `Q2_from_dsp` in `ROB_ID_TYPE`: producer tags. `ZERO_ROB` means the operand is ready.
- `pc_from_dsp` in 32: instruction PC.
- `imm_from_dsp` in 32: immediate.
- `rob_id_from_dsp` in `ROB_ID_TYPE`: destination ROB tag.
- `valid_from_Arith_unit_cdb` in 1, `rob_id_from_Arith_unit_cdb` in `ROB_ID_TYPE`, `result_from_Arith_unit_cdb` in 32: arith CDB broadcast.
- `valid_from_LS_unit_cdb` in 1, `rob_id_from_LS_unit_cdb` in `ROB_ID_TYPE`, `result_from_LS_unit_cdb` in 32: LS CDB broadcast.
- `misbranch_flag` in 1: flush.
- `full_to_if` out 1: stall request to the fetcher.
- `ena_to_alu` out 1: issue valid, registered.
- `openum_to_alu`, `V1_to_alu`, `V2_to_alu`, `pc_to_alu`, `imm_to_alu` out: issued payload, registered, with the same widths as the inputs.
- `rob_id_to_alu` out `ROB_ID_TYPE`: issued tag.

## Operation
- **Entry state:** each entry holds `busy`, openum, V1, V2, Q1, Q2, pc, imm and rob_id.
- **Allocation:** when `ena_from_dsp` is high, the instruction is written into the lowest-index non-busy entry.
  - Dispatch never arrives while the RS is full; the back-pressure margin guarantees this.
  - If it does anyway, the instruction is dropped. The bench flags this as an error.
- **Incoming snoop:** the incoming instruction is checked against both CDBs in the same cycle.
  - If Q1 or Q2 is non-zero and matches a valid CDB tag, the stored Q becomes `ZERO_ROB` and the stored V takes that CDB's result.
  - Arith CDB has priority if both CDBs carry the same tag, which is illegal but deterministic.
- **Wakeup:** for every busy entry, a Q that is non-zero and matches a valid CDB tag is cleared to `ZERO_ROB` and its V is loaded with the result. Both operands of one entry may wake in the same cycle, from the same or from different CDBs.
- **Select:** the lowest-index entry that is busy with Q1 = Q2 = `ZERO_ROB` (registered state) is issued.
  - Its payload is registered onto the ALU outputs with `ena_to_alu` = 1.
  - Its `busy` bit is cleared on the same edge.
  - If no entry is ready, `ena_to_alu` = 0 and the payload outputs hold their previous values.
- **Back-pressure:** `full_to_if` = (busy count ≥ `RS_SIZE` − 2), combinational from the registered busy vector. The two-entry margin covers one instruction in the dispatcher register and one in the fetch stage.
- **Flush:** when `misbranch_flag` is high, on the clock edge all `busy` bits are cleared and `ena_to_alu` goes to 0. Dispatch input in that cycle is ignored. Wakeup and issue in that cycle are suppressed.
- **Stall:** when `rdy` is low, there are no state or output changes, and CDB events in that cycle are not captured.

## Timing
- **Reset:** all `busy` bits = 0, `ena_to_alu` = 0, `openum_to_alu` = `OPENUM_NOP`, and every other `_to_alu` output = 0. `full_to_if` = 0 follows from the cleared busy bits.
- **Priority per edge:** `rst` > `~rdy` > `misbranch_flag` > normal operation.
- **Ready-at-dispatch:** an entry arriving at edge t with both operands ready can be selected at edge t+1. Its `ena_to_alu` is high during cycle t+1 → t+2, so minimum dispatch-to-ALU latency is 1 cycle in the RS.
- **Woken entry:** an entry woken by a CDB broadcast at edge t issues at edge t+1 at the earliest. Select uses only registered Q values.
- **Simultaneous events:** allocation, wakeup of other entries, and issue of a different entry all happen on the same edge. A freed slot is reusable from the next cycle. An entry issued at edge t is not woken or rewritten at edge t.
- **Reset mid-operation:** all in-flight entries are lost and no issue occurs in the cycle after reset.

## Structure
- `constant.v` holds `OPENUM_TYPE`, `OPENUM_NOP`, `ROB_ID_TYPE`, `ZERO_ROB`, `DATA_TYPE`, `ADDR_TYPE`, `TRUE`, `FALSE`, plus a new `RS_SIZE` and `RS_IDX_TYPE`.
- One sub-module, `rs_priority_finder`, is natural. It is a combinational lowest-set-bit encoder that outputs an index and a found flag. It is instantiated twice: once over ~busy (free slot) and once over the ready vector (issue).

## Test plan
- **Reset, then one ready ADD:** dispatch ADD with V1 = 5, V2 = 7, Q1 = Q2 = 0, rob_id = 3. Required: issue one cycle later with `ena_to_alu` = 1, V1 = 5, V2 = 7, rob_id = 3; `ena_to_alu` = 0 the following cycle.
- **Waiting operand, arith wakeup:** dispatch with Q1 = 4, V2 = 2. Two cycles later, arith CDB broadcasts tag 4 with result 0x10. Required: issue on the next edge with V1 = 0x10, and no issue before that.
- **Same-cycle dispatch and LS CDB:** dispatch with Q2 = 6 while the LS CDB broadcasts tag 6 with result 0xABCD in the same cycle. Required: issue the next cycle with V2 = 0xABCD.
- **Fill and back-pressure:** dispatch 14 entries all waiting on tag 9. Required: `full_to_if` rises once the count reaches 14. A broadcast of tag 9 then drains the entries in index order 0..13, one per cycle, and `full_to_if` falls when the count drops to 13.
- **Flush:** with 5 waiting entries, assert `misbranch_flag` together with a dispatch and a CDB hit. Required: all entries are gone, `ena_to_alu` = 0, and a later broadcast of the old tag issues nothing.
- **rdy low:** with a ready entry present, hold `rdy` = 0 for 3 cycles. Required: no issue and outputs unchanged; the entry issues on the first edge after `rdy` returns high.
